alu_seq_ctrl: RTL and testbench

Two-requester controller that owns the 32-bit ALU and sequences it. It arbitrates round-robin between requester ports 0 and 1 and drives the ALU opcode and operand buses. Multi-bit shifts are expanded into repeated single-bit SL/SR steps. Each result is returned with Z/N/C/V flags over a valid/ready response channel. The block sits between the instruction-issue logic and the ALU.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/alu_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode encoding, controller FSM states and flag layout shared by the
// ALU sequencing controller and the ALU itself.
package alu_pkg;

   localparam logic [4:0] OP_NOP = 5'h00;
   localparam logic [4:0] OP_LD  = 5'h01;
   localparam logic [4:0] OP_ADD = 5'h03;
   localparam logic [4:0] OP_SUB = 5'h04;
   localparam logic [4:0] OP_AND = 5'h05;
   localparam logic [4:0] OP_OR  = 5'h06;
   localparam logic [4:0] OP_XOR = 5'h07;
   localparam logic [4:0] OP_NOT = 5'h08;
   localparam logic [4:0] OP_SL  = 5'h09;
   localparam logic [4:0] OP_SR  = 5'h0A;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      SHIFT,
      RESP
   } ctrl_state_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   function automatic logic op_is_legal(input logic [4:0] op);
      case (op)
         OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOT, OP_SL, OP_SR: op_is_legal = 1'b1;
         default:                      op_is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic op_is_shift(input logic [4:0] op);
      op_is_shift = (op == OP_SL) || (op == OP_SR);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. last_grant resets to 1 so port 0 wins the
// first contested grant; it only moves on an accepted request.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic       grant_o,
   output logic       any_o
);

   logic last_grant_q, last_grant_d;

   always_comb begin
      grant_o = ~last_grant_q;
      if (req_i == 2'b01) begin
         grant_o = 1'b0;
      end else if (req_i == 2'b10) begin
         grant_o = 1'b1;
      end
   end

   assign any_o = |req_i;

   always_comb begin
      last_grant_d = last_grant_q;
      if (accept_i) begin
         last_grant_d = grant_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Two-requester ALU sequencer: arbitrates, drives the ALU, expands multi-bit
// shifts into single-bit steps and returns result/flags on a valid/ready port.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0][4:0]       req_op,
   input  logic [1:0][WIDTH-1:0] req_a,
   input  logic [1:0][WIDTH-1:0] req_b,
   output logic [4:0]            alu_op,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   input  logic [WIDTH-1:0]      alu_result,
   input  logic                  alu_z,
   input  logic                  alu_n,
   input  logic                  alu_c,
   input  logic                  alu_v,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [WIDTH-1:0]      rsp_result,
   output logic [3:0]            rsp_flags,
   output logic                  rsp_err
);

   ctrl_state_e        state_q, state_d;
   logic [4:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   alu_flags_t         flags_q, flags_d;
   logic               err_q, err_d;
   logic               id_q, id_d;

   logic               grant;
   logic               req_any;
   logic               req_accept;
   logic [4:0]         op_g;
   logic [WIDTH-1:0]   a_g;
   logic [WIDTH-1:0]   b_g;
   logic [SHAMT_W-1:0] shamt_g;
   alu_flags_t         alu_flags;

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst_n    (reset),
      .req_i    (req_valid),
      .accept_i (req_accept),
      .grant_o  (grant),
      .any_o    (req_any)
   );

   assign req_accept = (state_q == IDLE) && req_any;
   assign op_g       = req_op[grant];
   assign a_g        = req_a[grant];
   assign b_g        = req_b[grant];
   assign shamt_g    = b_g[SHAMT_W-1:0];
   assign alu_flags  = {alu_z, alu_n, alu_c, alu_v};

   // Gated by reset so no accept is advertised while the block is held in reset.
   always_comb begin
      req_ready = 2'b00;
      if (reset && req_accept) begin
         req_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      alu_op = OP_NOP;
      alu_a  = '0;
      alu_b  = '0;
      case (state_q)
         EXEC: begin
            alu_op = op_q;
            alu_a  = a_q;
            alu_b  = b_q;
         end
         SHIFT: begin
            alu_op = op_q;
            alu_a  = a_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_accept) begin
               op_d  = op_g;
               a_d   = a_g;
               b_d   = b_g;
               id_d  = grant;
               cnt_d = shamt_g;
               err_d = 1'b0;
               if (!op_is_legal(op_g)) begin
                  result_d = '0;
                  flags_d  = '0;
                  err_d    = 1'b1;
                  state_d  = RESP;
               end else if (op_is_shift(op_g) && (shamt_g == '0)) begin
                  result_d = a_g;
                  flags_d  = '{z: (a_g == '0), n: a_g[WIDTH-1], c: 1'b0, v: 1'b0};
                  state_d  = RESP;
               end else if (op_is_shift(op_g)) begin
                  state_d = SHIFT;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            result_d = alu_result;
            flags_d  = alu_flags;
            state_d  = RESP;
         end
         // a_q doubles as the shift work register; flags end up from the last step.
         SHIFT: begin
            a_d      = alu_result;
            result_d = alu_result;
            flags_d  = alu_flags;
            cnt_d    = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         op_q     <= OP_NOP;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         err_q    <= err_d;
      end
   end

   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = id_q;
   assign rsp_result = result_q;
   assign rsp_flags  = flags_q;
   assign rsp_err    = err_q;

   a_ready_onehot: assert property (@(posedge clk) disable iff (!reset)
      $onehot0(req_ready));

   a_rsp_hold: assert property (@(posedge clk) disable iff (!reset)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result) &&
      $stable(rsp_flags) && $stable(rsp_err) && $stable(rsp_id)));

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized self-checking bench for alu_seq_ctrl with a behavioural ALU and
// a transaction-level reference model of results, flags, grants and latency.
module tb_alu_seq_ctrl;

   localparam logic [4:0] OPC_LD  = 5'h01;
   localparam logic [4:0] OPC_ADD = 5'h03;
   localparam logic [4:0] OPC_SUB = 5'h04;
   localparam logic [4:0] OPC_AND = 5'h05;
   localparam logic [4:0] OPC_OR  = 5'h06;
   localparam logic [4:0] OPC_XOR = 5'h07;
   localparam logic [4:0] OPC_NOT = 5'h08;
   localparam logic [4:0] OPC_SL  = 5'h09;
   localparam logic [4:0] OPC_SR  = 5'h0A;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   typedef struct {
      logic [31:0] r;
      logic [3:0]  f;
      logic        e;
      logic        id;
      int          acc;
      int          lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][4:0]  req_op;
   logic [1:0][31:0] req_a;
   logic [1:0][31:0] req_b;
   logic [4:0]       alu_op;
   logic [31:0]      alu_a, alu_b, alu_result;
   logic             alu_z, alu_n, alu_c, alu_v;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [31:0]      rsp_result;
   logic [3:0]       rsp_flags;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   bit          busy = 0;
   logic        m_last = 1'b1;
   exp_t        cur;
   req_t        pq0[$];
   req_t        pq1[$];
   int          hold_cnt = 0;
   bit          rand_ready = 0;
   bit          prev_valid = 0;
   bit          prev_ready = 0;
   logic [37:0] prev_fields = '0;

   alu_seq_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_z      (alu_z),
      .alu_n      (alu_n),
      .alu_c      (alu_c),
      .alu_v      (alu_v),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   // Behavioural single-step ALU: SL/SR move one bit, C is the bit shifted out.
   always_comb begin
      logic [32:0] w;
      w          = '0;
      alu_result = '0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      case (alu_op)
         OPC_LD:  alu_result = alu_b;
         OPC_ADD: begin
            w          = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = w[31:0];
            alu_c      = w[32];
            alu_v      = (alu_a[31] == alu_b[31]) && (w[31] != alu_a[31]);
         end
         OPC_SUB: begin
            w          = {1'b0, alu_a} - {1'b0, alu_b};
            alu_result = w[31:0];
            alu_c      = w[32];
            alu_v      = (alu_a[31] != alu_b[31]) && (w[31] != alu_a[31]);
         end
         OPC_AND: alu_result = alu_a & alu_b;
         OPC_OR:  alu_result = alu_a | alu_b;
         OPC_XOR: alu_result = alu_a ^ alu_b;
         OPC_NOT: alu_result = ~alu_a;
         OPC_SL: begin
            alu_result = {alu_a[30:0], 1'b0};
            alu_c      = alu_a[31];
         end
         OPC_SR: begin
            alu_result = {1'b0, alu_a[31:1]};
            alu_c      = alu_a[0];
         end
         default: alu_result = '0;
      endcase
      alu_z = (alu_result == 32'd0);
      alu_n = alu_result[31];
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t ref_model(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic id, input int acc);
      exp_t   x;
      int     k;
      longint s;
      logic   c, v;
      k     = int'(b[4:0]);
      c     = 1'b0;
      v     = 1'b0;
      x.e   = 1'b0;
      x.id  = id;
      x.acc = acc;
      x.lat = 2;
      x.r   = '0;
      case (op)
         OPC_LD:  x.r = b;
         OPC_ADD: begin
            x.r = a + b;
            c   = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
            s   = longint'($signed(a)) + longint'($signed(b));
            v   = s != longint'($signed(x.r));
         end
         OPC_SUB: begin
            x.r = a - b;
            c   = a < b;
            s   = longint'($signed(a)) - longint'($signed(b));
            v   = s != longint'($signed(x.r));
         end
         OPC_AND: x.r = a & b;
         OPC_OR:  x.r = a | b;
         OPC_XOR: x.r = a ^ b;
         OPC_NOT: x.r = ~a;
         OPC_SL: begin
            x.r   = a << k;
            c     = (k == 0) ? 1'b0 : a[32-k];
            x.lat = 1 + k;
         end
         OPC_SR: begin
            x.r   = a >> k;
            c     = (k == 0) ? 1'b0 : a[k-1];
            x.lat = 1 + k;
         end
         default: begin
            x.e   = 1'b1;
            x.lat = 1;
         end
      endcase
      x.f = x.e ? 4'b0000 : {x.r == 32'd0, x.r[31], c, v};
      return x;
   endfunction

   task automatic load_port(input int p);
      req_t q;
      if ((p == 0 && pq0.size() == 0) || (p == 1 && pq1.size() == 0)) begin
         req_valid[p] = 1'b0;
      end else begin
         q            = (p == 0) ? pq0[0] : pq1[0];
         req_valid[p] = 1'b1;
         req_op[p]    = q.op;
         req_a[p]     = q.a;
         req_b[p]     = q.b;
      end
   endtask

   task automatic enq(input int p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      req_t q;
      q.op = op;
      q.a  = a;
      q.b  = b;
      if (p == 0) pq0.push_back(q);
      else        pq1.push_back(q);
      if (!req_valid[p]) load_port(p);
   endtask

   // One clock: sample/check at negedge, update stimulus 1 unit after posedge.
   task automatic step();
      logic [1:0]  exp_rdy;
      logic        g;
      bit          popg;
      logic [37:0] fields;
      popg = 0;
      g    = 1'b0;
      @(negedge clk);
      exp_rdy = 2'b00;
      if (!busy && req_valid != 2'b00) begin
         g          = (req_valid == 2'b11) ? ~m_last : req_valid[1];
         exp_rdy[g] = 1'b1;
      end
      check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
      fields = {rsp_id, rsp_err, rsp_flags, rsp_result};
      if (!busy) begin
         check_eq("rsp_valid_idle", 64'(rsp_valid), 64'd0);
         check_eq("alu_op_idle", 64'(alu_op), 64'd0);
         check_eq("alu_ab_idle", {alu_a, alu_b}, 64'd0);
      end else begin
         if (prev_valid && !prev_ready) begin
            check_eq("rsp_hold", 64'(rsp_valid), 64'd1);
            check_eq("rsp_stable", 64'(fields), 64'(prev_fields));
         end
         if (rsp_valid) begin
            check_eq("alu_op_resp", 64'(alu_op), 64'd0);
            check_eq("alu_ab_resp", {alu_a, alu_b}, 64'd0);
            if (!prev_valid) check_eq("latency", 64'(cyc - cur.acc), 64'(cur.lat));
            if (rsp_ready) begin
               check_eq("rsp_result", 64'(rsp_result), 64'(cur.r));
               check_eq("rsp_flags", 64'(rsp_flags), 64'(cur.f));
               check_eq("rsp_err", 64'(rsp_err), 64'(cur.e));
               check_eq("rsp_id", 64'(rsp_id), 64'(cur.id));
               busy = 0;
            end
         end
      end
      if (exp_rdy != 2'b00) begin
         cur    = ref_model(req_op[g], req_a[g], req_b[g], g, cyc);
         busy   = 1;
         m_last = g;
         popg   = 1;
      end
      prev_valid  = rsp_valid;
      prev_ready  = rsp_ready;
      prev_fields = fields;
      @(posedge clk);
      cyc++;
      #1;
      if (popg) begin
         if (g == 1'b0) void'(pq0.pop_front());
         else           void'(pq1.pop_front());
         load_port(int'(g));
      end
      if (hold_cnt > 0) begin
         if (prev_valid) hold_cnt--;
         rsp_ready = (hold_cnt == 0);
      end else begin
         rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic play(input int budget);
      int start;
      start = cyc;
      while ((pq0.size() != 0 || pq1.size() != 0 || busy) && (cyc - start < budget)) step();
      check_eq("drained", 64'(pq0.size() + pq1.size() + int'(busy)), 64'd0);
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      check_eq({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
      check_eq({tag, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
      check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
      check_eq({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
      check_eq({tag, "_alu_op"}, 64'(alu_op), 64'd0);
      check_eq({tag, "_alu_a"}, 64'(alu_a), 64'd0);
      check_eq({tag, "_alu_b"}, 64'(alu_b), 64'd0);
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [4:0] rand_op();
      case ($urandom_range(0, 11))
         0:  return OPC_LD;
         1:  return OPC_ADD;
         2:  return OPC_SUB;
         3:  return OPC_AND;
         4:  return OPC_OR;
         5:  return OPC_XOR;
         6:  return OPC_NOT;
         7, 8:  return OPC_SL;
         9, 10: return OPC_SR;
         default: begin
            case ($urandom_range(0, 2))
               0:       return 5'h00;
               1:       return 5'h02;
               default: return 5'($urandom_range(11, 31));
            endcase
         end
      endcase
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      req_valid = 2'b00;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      enq(0, OPC_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
      play(50);

      enq(1, OPC_SL, 32'h8000_0001, 32'd4);
      enq(1, OPC_SL, 32'h8000_0001, 32'd1);
      enq(1, OPC_SL, 32'h8000_0001, 32'd0);
      play(100);

      enq(0, OPC_ADD, 32'd2, 32'd3);
      enq(0, OPC_ADD, 32'd2, 32'd3);
      enq(1, OPC_SUB, 32'd5, 32'd7);
      enq(1, OPC_SUB, 32'd5, 32'd7);
      play(100);

      enq(0, 5'h02, 32'd5, 32'd0);
      play(50);

      hold_cnt  = 10;
      rsp_ready = 1'b0;
      enq(0, OPC_XOR, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
      step();
      enq(1, OPC_OR, 32'h1234_0000, 32'h0000_5678);
      play(100);

      enq(0, OPC_SR, 32'hF000_0001, 32'd20);
      step();
      enq(1, OPC_AND, 32'hFFFF_0000, 32'h00FF_FF00);
      repeat (5) step();
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      busy       = 0;
      pq0.delete();
      pq1.delete();
      req_valid  = 2'b00;
      m_last     = 1'b1;
      prev_valid = 0;
      prev_ready = 0;
      hold_cnt   = 0;
      rsp_ready  = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      enq(1, OPC_NOT, 32'h0F0F_0F0F, 32'd0);
      enq(0, OPC_SUB, 32'h8000_0000, 32'd1);
      play(100);

      rand_ready = 1;
      for (int unsigned batch = 0; batch < 30; batch++) begin
         for (int unsigned n = 0; n < $urandom_range(1, 6); n++) begin
            enq(int'($urandom_range(0, 1)), rand_op(), rand_word(), rand_word());
         end
         play(3000);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
